pc_predict: RTL and testbench

// - Fetch-stage PC register plus branch predictor; sits directly upstream of the next-PC select mux.
// - Registers the selected next PC and exposes it as the current fetch PC.
// - Predicts the following PC from a 2-bit BHT and a direct-mapped BTB. The prediction feeds the

---
 rtl/pc_predict_pkg.sv | 30 +++
 rtl/pc_predict_bht.sv | 38 +++
 rtl/pc_predict.sv | 109 ++++++++++
 tb/tb_pc_predict.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pc_predict_pkg.sv
// pc_predict_pkg
// Shared definitions for the fetch-stage PC register and branch predictor:
//   PC_WIDTH / PC_RESET  - architectural PC width and fetch PC after reset
//   bht_ctr_e            - 2-bit branch history counter encodings
//   ctr_next()           - saturating counter update
package pc_predict_pkg;

    localparam int                   PC_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0]  PC_RESET = 32'h0000_0000;

    typedef enum logic [1:0] {
        SNT = 2'b00,   // strongly not-taken
        WNT = 2'b01,   // weakly not-taken (reset value)
        WT  = 2'b10,   // weakly taken
        ST  = 2'b11    // strongly taken
    } bht_ctr_e;

    // Saturating 2-bit update: taken counts up to ST, not-taken down to SNT.
    function automatic logic [1:0] ctr_next(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = cur + 2'd1;
        end else begin
            if (cur != SNT) nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pc_predict_bht.sv
// bht_counter_array
// Branch history table: ENTRIES 2-bit saturating counters.
//   clk, rst   - clock, synchronous active-high reset (all counters -> WNT)
//   rd_idx     - read index (combinational read, pre-update value)
//   rd_ctr     - counter at rd_idx
//   wr_en      - train this cycle
//   wr_idx     - index being trained
//   wr_taken   - resolved direction
module bht_counter_array
    import pc_predict_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] ctr [ENTRIES];

    // Reset has priority, so a training update in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= WNT;
        end else if (wr_en) begin
            ctr[wr_idx] <= ctr_next(ctr[wr_idx], wr_taken);
        end
    end

    // No write-to-read bypass: the prediction sees the value before this edge's update.
    assign rd_ctr = ctr[rd_idx];

endmodule

// File: rtl/pc_predict.sv
// pc_predict
// Fetch PC register plus 2-bit BHT / direct-mapped BTB predictor. The predicted
// next PC feeds the next-PC select mux as its default input.
//   clk, rst        - clock, synchronous active-high reset
//   F_stall_i       - hold the fetch PC
//   F_sel_PC_i      - next PC chosen by the select mux
//   F_PC_o          - current fetch PC (registered)
//   F_pred_PC_o     - predicted next PC
//   F_pred_taken_o  - taken prediction for F_PC_o
//   D_br_valid_i    - decode resolved a conditional branch (training strobe)
//   D_br_taken_i    - resolved direction
//   D_br_PC_i       - PC of the resolved branch
//   D_br_target_i   - resolved taken target
module pc_predict
    import pc_predict_pkg::*;
#(
    parameter int                  PC_WIDTH    = pc_predict_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] PC_RESET    = pc_predict_pkg::PC_RESET,
    parameter int                  BHT_ENTRIES = 64,
    parameter int                  BTB_ENTRIES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                F_stall_i,
    input  logic [PC_WIDTH-1:0] F_sel_PC_i,
    output logic [PC_WIDTH-1:0] F_PC_o,
    output logic [PC_WIDTH-1:0] F_pred_PC_o,
    output logic                F_pred_taken_o,
    input  logic                D_br_valid_i,
    input  logic                D_br_taken_i,
    input  logic [PC_WIDTH-1:0] D_br_PC_i,
    input  logic [PC_WIDTH-1:0] D_br_target_i
);

    localparam int BHT_IW = $clog2(BHT_ENTRIES);
    localparam int BTB_IW = $clog2(BTB_ENTRIES);
    localparam int TAG_W  = PC_WIDTH - BTB_IW - 2;

    logic [PC_WIDTH-1:0] pc_q;

    logic                btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0]    btb_tag    [BTB_ENTRIES];
    logic [PC_WIDTH-1:0] btb_target [BTB_ENTRIES];

    // Fetch-side indices (bits [1:0] never index anything).
    logic [BHT_IW-1:0] f_bidx;
    logic [BTB_IW-1:0] f_tidx;
    logic [TAG_W-1:0]  f_tag;
    // Decode-side (training) indices.
    logic [BHT_IW-1:0] d_bidx;
    logic [BTB_IW-1:0] d_tidx;
    logic [TAG_W-1:0]  d_tag;

    logic [1:0] f_ctr;
    logic       hit;

    assign f_bidx = pc_q[BHT_IW+1:2];
    assign f_tidx = pc_q[BTB_IW+1:2];
    assign f_tag  = pc_q[PC_WIDTH-1:BTB_IW+2];
    assign d_bidx = D_br_PC_i[BHT_IW+1:2];
    assign d_tidx = D_br_PC_i[BTB_IW+1:2];
    assign d_tag  = D_br_PC_i[PC_WIDTH-1:BTB_IW+2];

    logic unused_br_lsb;
    assign unused_br_lsb = ^D_br_PC_i[1:0];

    // PC register. A redirect arriving while stalled is lost by design.
    always_ff @(posedge clk) begin
        if (rst)             pc_q <= PC_RESET;
        else if (!F_stall_i) pc_q <= F_sel_PC_i;
    end

    bht_counter_array #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (BHT_IW)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (f_bidx),
        .rd_ctr   (f_ctr),
        .wr_en    (D_br_valid_i),
        .wr_idx   (d_bidx),
        .wr_taken (D_br_taken_i)
    );

    // BTB valid bits: only these need reset; a taken branch claims its slot
    // unconditionally, not-taken branches leave the BTB alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
        end else if (D_br_valid_i && D_br_taken_i) begin
            btb_valid[d_tidx] <= 1'b1;
        end
    end

    // Tag/target payload is qualified by the valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
        if (!rst && D_br_valid_i && D_br_taken_i) begin
            btb_tag[d_tidx]    <= d_tag;
            btb_target[d_tidx] <= D_br_target_i;
        end
    end

    assign hit            = btb_valid[f_tidx] && (btb_tag[f_tidx] == f_tag);
    assign F_pred_taken_o = hit && f_ctr[1];
    assign F_pred_PC_o    = F_pred_taken_o ? btb_target[f_tidx] : pc_q + PC_WIDTH'(4);
    assign F_PC_o         = pc_q;

endmodule

// File: tb/tb_pc_predict.sv
module tb_pc_predict;

    logic        clk = 1'b0;
    logic        rst;
    logic        F_stall_i;
    logic [31:0] F_sel_PC_i;
    logic [31:0] F_PC_o;
    logic [31:0] F_pred_PC_o;
    logic        F_pred_taken_o;
    logic        D_br_valid_i;
    logic        D_br_taken_i;
    logic [31:0] D_br_PC_i;
    logic [31:0] D_br_target_i;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pc_predict dut (
        .clk            (clk),
        .rst            (rst),
        .F_stall_i      (F_stall_i),
        .F_sel_PC_i     (F_sel_PC_i),
        .F_PC_o         (F_PC_o),
        .F_pred_PC_o    (F_pred_PC_o),
        .F_pred_taken_o (F_pred_taken_o),
        .D_br_valid_i   (D_br_valid_i),
        .D_br_taken_i   (D_br_taken_i),
        .D_br_PC_i      (D_br_PC_i),
        .D_br_target_i  (D_br_target_i)
    );

    // ---------------- behavioural model ----------------
    // Counters held as plain integers 0..3; BTB slots remember the full branch PC
    // and hit when the PC bits above the slot index agree.
    int          m_ctr    [64];
    bit          m_valid  [16];
    logic [31:0] m_brpc   [16];
    logic [31:0] m_target [16];
    logic [31:0] m_pc;

    function automatic bit m_taken();
        int t, b;
        t = int'((m_pc >> 2) % 16);
        b = int'((m_pc >> 2) % 64);
        return m_valid[t] && ((m_brpc[t] >> 6) == (m_pc >> 6)) && (m_ctr[b] >= 2);
    endfunction

    function automatic logic [31:0] m_pred();
        if (m_taken()) return m_target[int'((m_pc >> 2) % 16)];
        return m_pc + 32'd4;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 32'h0;
            for (int i = 0; i < 64; i++) m_ctr[i] = 1;
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        end else begin
            if (!F_stall_i) m_pc = F_sel_PC_i;
            if (D_br_valid_i) begin
                int b, t;
                b = int'((D_br_PC_i >> 2) % 64);
                t = int'((D_br_PC_i >> 2) % 16);
                if (D_br_taken_i) begin
                    if (m_ctr[b] < 3) m_ctr[b] = m_ctr[b] + 1;
                    m_valid[t]  = 1'b1;
                    m_brpc[t]   = D_br_PC_i;
                    m_target[t] = D_br_target_i;
                end else if (m_ctr[b] > 0) begin
                    m_ctr[b] = m_ctr[b] - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_pc",    F_PC_o,                m_pc);
            chk("model_taken", {31'b0, F_pred_taken_o}, {31'b0, m_taken()});
            chk("model_pred",  F_pred_PC_o,           m_pred());
        end
    end

    // Inputs change 2 time units after the edge, so DUT and model sample stable values.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        D_br_valid_i  = 1'b1;
        D_br_PC_i     = pc;
        D_br_target_i = tgt;
        D_br_taken_i  = taken;
    endtask

    initial begin
        rst = 1'b1; F_stall_i = 1'b0; F_sel_PC_i = 32'h0;
        D_br_valid_i = 1'b0; D_br_taken_i = 1'b0; D_br_PC_i = 32'h0; D_br_target_i = 32'h0;
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state and sequential fetch
        chk("rst_pc", F_PC_o, 32'h0);
        chk("rst_pred", F_pred_PC_o, 32'h4);
        chk("rst_taken", {31'b0, F_pred_taken_o}, 32'h0);
        F_sel_PC_i = F_pred_PC_o; tick();
        chk("seq_pc1", F_PC_o, 32'h4);
        F_sel_PC_i = F_pred_PC_o; tick();
        chk("seq_pc2", F_PC_o, 32'h8);

        // One taken training -> WT, BTB hit
        F_stall_i = 1'b1;
        train(32'h40, 32'h100, 1'b1); tick();
        D_br_valid_i = 1'b0; F_stall_i = 1'b0; F_sel_PC_i = 32'h40; tick();
        chk("train_taken", {31'b0, F_pred_taken_o}, 32'h1);
        chk("train_pred", F_pred_PC_o, 32'h100);

        // Saturation (pc held at 0x40 by stall)
        F_stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin train(32'h40, 32'h100, 1'b1); tick(); end
        train(32'h40, 32'h100, 1'b0); tick();
        chk("sat_nt1_pred", F_pred_PC_o, 32'h100);
        train(32'h40, 32'h100, 1'b0); tick();
        chk("sat_nt2_pred", F_pred_PC_o, 32'h44);
        chk("sat_nt2_taken", {31'b0, F_pred_taken_o}, 32'h0);

        // Aliasing: 0x80 shares the BTB slot of 0x40 but not its tag
        train(32'h40, 32'h100, 1'b1); tick();
        D_br_valid_i = 1'b0; F_stall_i = 1'b0; F_sel_PC_i = 32'h80; tick();
        chk("alias_pred", F_pred_PC_o, 32'h84);

        // Stall with training underneath
        F_sel_PC_i = 32'h200; tick();
        F_stall_i = 1'b1; F_sel_PC_i = 32'h300;
        for (int i = 0; i < 3; i++) begin
            train(32'h40, 32'h140, 1'b1); tick();
            chk("stall_hold", F_PC_o, 32'h200);
        end
        D_br_valid_i = 1'b0; F_stall_i = 1'b0; F_sel_PC_i = 32'h40; tick();
        chk("stall_after_pred", F_pred_PC_o, 32'h140);

        // Wrap-around of pc+4
        F_sel_PC_i = 32'hFFFF_FFFC; tick();
        chk("wrap_pred", F_pred_PC_o, 32'h0);

        // Reset during training: update discarded
        rst = 1'b1; train(32'h40, 32'h180, 1'b1); tick();
        rst = 1'b0; D_br_valid_i = 1'b0; F_sel_PC_i = 32'h40; tick();
        chk("rst_train_taken", {31'b0, F_pred_taken_o}, 32'h0);
        chk("rst_train_pred", F_pred_PC_o, 32'h44);
        chk("rst_train_ctr", {30'b0, dut.u_bht.ctr[16]}, 32'h1);

        // Randomized traffic, checked every cycle by the compare process
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] rpc;
            rst       = ($urandom_range(0, 199) == 0);
            F_stall_i = ($urandom_range(0, 3) == 0);
            rpc = ({30'($urandom_range(0, 3)), 12'h0}) | (32'($urandom_range(0, 63)) << 2);
            if ($urandom_range(0, 99) == 0) rpc = 32'hFFFF_FFFC;
            F_sel_PC_i = $urandom_range(0, 1) ? F_pred_PC_o : rpc;
            D_br_valid_i = $urandom_range(0, 1);
            D_br_taken_i = ($urandom_range(0, 2) != 0);
            D_br_PC_i = ({30'($urandom_range(0, 3)), 12'h0}) | (32'($urandom_range(0, 63)) << 2);
            D_br_target_i = $urandom & 32'hFFFF_FFFC;
            tick();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
